two_dimension_demux_buffer: RTL and testbench

Registered 1-to-2 demultiplexer for a 4x4 byte AES state (one share). An incoming 16-byte state is written into one of two holding banks chosen by `select`, and each bank is drained by its own consumer through a valid/ack handshake. The block sits on the return path of the datapath, steering a round result back to one of two state consumers. Bank contents are zeroed on drain so stale share data does not linger in registers.

---
 rtl/two_dimension_demux_buffer.sv | 94 +++++++++
 tb/tb_two_dimension_demux_buffer.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/two_dimension_demux_buffer.sv
// Registered 1-to-2 demux for a 16-byte AES state share: each accepted state lands in
// one of two holding banks, each drained by its own consumer via valid/ack.

module two_dimension_demux_buffer_bank #(
    parameter int STATE_W = 128
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [STATE_W-1:0] wr_data,
    input  logic               ack,
    output logic               valid,
    output logic [STATE_W-1:0] data
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} bank_state_e;

    bank_state_e state, state_nxt;
    logic        drain;

    assign valid = (state == FULL);
    assign drain = valid & ack;

    always_comb begin
        state_nxt = state;
        if (wr_en)      state_nxt = FULL;
        else if (drain) state_nxt = EMPTY;
    end

    // A write in the drain cycle wins, so a continuously acked bank never shows a zero cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
            data  <= '0;
        end else begin
            state <= state_nxt;
            if (wr_en)      data <= wr_data;
            else if (drain) data <= '0;
        end
    end
endmodule

module two_dimension_demux_buffer #(
    parameter int BYTE_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 select,
    input  logic [16*BYTE_W-1:0] in_state,
    output logic [16*BYTE_W-1:0] out1_state,
    output logic                 out1_valid,
    input  logic                 out1_ack,
    output logic [16*BYTE_W-1:0] out2_state,
    output logic                 out2_valid,
    input  logic                 out2_ack,
    output logic                 overflow_err
);
    localparam int NUM_BANKS = 2;
    localparam int STATE_W   = 16 * BYTE_W;

    // Index 0 is bank 1 (select=1), index 1 is bank 2 (select=0).
    logic [NUM_BANKS-1:0]              wr_en, ack, valid;
    logic [NUM_BANKS-1:0][STATE_W-1:0] data;
    logic                              accept;

    assign ack = {out2_ack, out1_ack};

    assign in_ready = select ? (!valid[0] | ack[0]) : (!valid[1] | ack[1]);
    assign accept   = in_valid & in_ready;
    assign wr_en    = {accept & !select, accept & select};

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        two_dimension_demux_buffer_bank #(.STATE_W(STATE_W)) u_bank (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (wr_en[b]),
            .wr_data (in_state),
            .ack     (ack[b]),
            .valid   (valid[b]),
            .data    (data[b])
        );
    end

    assign out1_state = data[0];
    assign out1_valid = valid[0];
    assign out2_state = data[1];
    assign out2_valid = valid[1];

    always_ff @(posedge clk) begin
        if (rst)                        overflow_err <= 1'b0;
        else if (in_valid && !in_ready) overflow_err <= 1'b1;
    end
endmodule

// File: tb/tb_two_dimension_demux_buffer.sv
// Directed bench for two_dimension_demux_buffer with hand-computed expectations.

module tb_two_dimension_demux_buffer;
    localparam int BYTE_W = 8;
    localparam int SW     = 16 * BYTE_W;

    logic          clk = 1'b0;
    logic          rst, in_valid, select, out1_ack, out2_ack;
    logic          in_ready, out1_valid, out2_valid, overflow_err;
    logic [SW-1:0] in_state, out1_state, out2_state;

    int n_vec = 0;
    int n_err = 0;

    two_dimension_demux_buffer #(.BYTE_W(BYTE_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .select       (select),
        .in_state     (in_state),
        .out1_state   (out1_state),
        .out1_valid   (out1_valid),
        .out1_ack     (out1_ack),
        .out2_state   (out2_state),
        .out2_valid   (out2_valid),
        .out2_ack     (out2_ack),
        .overflow_err (overflow_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [SW-1:0] act, input logic [SW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Advance one edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    localparam logic [SW-1:0] ST_SEQ = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [SW-1:0] ST_A5  = {16{8'hA5}};
    localparam logic [SW-1:0] ST_5A  = {16{8'h5A}};
    localparam logic [SW-1:0] ST_11  = {16{8'h11}};
    localparam logic [SW-1:0] ST_22  = {16{8'h22}};
    localparam logic [SW-1:0] ST_33  = {16{8'h33}};

    initial begin
        rst = 1'b1; in_valid = 1'b0; select = 1'b0; in_state = '0;
        out1_ack = 1'b0; out2_ack = 1'b0;
        step();
        step();
        rst = 1'b0;

        // reset state
        chk("rst_v1", out1_valid, 0);
        chk("rst_v2", out2_valid, 0);
        chk("rst_s1", out1_state, 0);
        chk("rst_s2", out2_state, 0);
        chk("rst_ovf", overflow_err, 0);
        select = 1'b1; #1 chk("rst_rdy_sel1", in_ready, 1);
        select = 1'b0; #1 chk("rst_rdy_sel0", in_ready, 1);

        // row-major byte pattern into bank 1
        in_valid = 1'b1; select = 1'b1; in_state = ST_SEQ;
        step();
        in_valid = 1'b0;
        chk("seq_v1", out1_valid, 1);
        chk("seq_s1", out1_state, ST_SEQ);
        chk("seq_v2", out2_valid, 0);
        chk("seq_s2", out2_state, 0);

        // fill bank 2, then overflow it
        in_valid = 1'b1; select = 1'b0; in_state = ST_A5;
        step();
        chk("a5_v2", out2_valid, 1);
        chk("a5_s2", out2_state, ST_A5);
        in_state = ST_5A;
        #1 chk("ovf_rdy", in_ready, 0);
        step();
        in_valid = 1'b0;
        chk("ovf_s2", out2_state, ST_A5);
        chk("ovf_set", overflow_err, 1);
        chk("ovf_s1_kept", out1_state, ST_SEQ);
        repeat (10) step();
        chk("ovf_sticky", overflow_err, 1);
        chk("ovf_s2_idle", out2_state, ST_A5);

        // write-with-drain on bank 1: 0x11 then 0x22, no zero cycle
        select = 1'b1; out1_ack = 1'b1; in_valid = 1'b1; in_state = ST_11;
        step();
        chk("wd11_s1", out1_state, ST_11);
        in_state = ST_22;
        #1 chk("wd_rdy", in_ready, 1);
        step();
        chk("wd22_v1", out1_valid, 1);
        chk("wd22_s1", out1_state, ST_22);

        // pure drain of bank 1, then ack while empty
        in_valid = 1'b0;
        step();
        chk("drain_v1", out1_valid, 0);
        chk("drain_s1", out1_state, 0);
        step();
        out1_ack = 1'b0;
        chk("idle_ack_v1", out1_valid, 0);
        chk("idle_ack_s1", out1_state, 0);
        chk("drain_s2_kept", out2_state, ST_A5);

        // both full, reset together with ack and offer
        in_valid = 1'b1; select = 1'b1; in_state = ST_33;
        step();
        chk("pre_rst_v1", out1_valid, 1);
        chk("pre_rst_v2", out2_valid, 1);
        rst = 1'b1; out1_ack = 1'b1; in_state = ST_SEQ;
        step();
        rst = 1'b0; out1_ack = 1'b0; in_valid = 1'b0;
        chk("mid_rst_v1", out1_valid, 0);
        chk("mid_rst_v2", out2_valid, 0);
        chk("mid_rst_s1", out1_state, 0);
        chk("mid_rst_s2", out2_state, 0);
        chk("mid_rst_ovf", overflow_err, 0);
        select = 1'b0; #1 chk("mid_rst_rdy0", in_ready, 1);
        select = 1'b1; #1 chk("mid_rst_rdy1", in_ready, 1);

        // alternating back-to-back offers with both acks held
        out1_ack = 1'b1; out2_ack = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic [SW-1:0] d;
            d = {16{8'(8'hC0 + i)}};
            in_valid = 1'b1; select = (i % 2 == 0); in_state = d;
            #1 chk("alt_rdy", in_ready, 1);
            step();
            if (i % 2 == 0) begin
                chk("alt_s1", out1_state, d);
                chk("alt_v1", out1_valid, 1);
                chk("alt_s2_drained", out2_state, 0);
                chk("alt_v2_drained", out2_valid, 0);
            end else begin
                chk("alt_s2", out2_state, d);
                chk("alt_v2", out2_valid, 1);
                chk("alt_s1_drained", out1_state, 0);
                chk("alt_v1_drained", out1_valid, 0);
            end
        end
        in_valid = 1'b0;
        chk("alt_no_ovf", overflow_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
